// File: rtl/booth_ctrl_if.sv
// Control bundle between the Booth sequencer and its datapath (A/Q shift
// registers, M register, A+/-M adder).
//
// Handshake: start is a request that the controller takes only while idle
// (busy=0); a start seen while busy=1 is dropped, never queued. done is a
// one-cycle pulse, raised while busy is still high, that marks {A,Q} valid.
interface booth_ctrl_if;
  logic start;
  logic q0;
  logic busy;
  logic done;
  logic ldm;
  logic ldq;
  logic clra;
  logic lda;
  logic addsub;
  logic sfta;
  logic sftq;
  logic qm1;

  modport master (
    output start, q0,
    input  busy, done, ldm, ldq, clra, lda, addsub, sfta, sftq, qm1
  );

  modport slave (
    input  start, q0,
    output busy, done, ldm, ldq, clra, lda, addsub, sfta, sftq, qm1
  );
endinterface

// File: rtl/booth_ctrl.sv
// Radix-2 Booth multiplier sequencer: drives the A/Q/M register strobes and owns Q-1 and the count.
// Optional BOOTH_SKIP_EN: on {q0,qm1}=00/11 the shift happens in the CHECK cycle itself.
module booth_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         clr,
  booth_ctrl_if.slave  bus,
  output logic [2:0]   o_dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_qm1;
  logic          w_qm1_nxt;

  logic w_ldm;
  logic w_ldq;
  logic w_clra;
  logic w_lda;
  logic w_addsub;
  logic w_sfta;
  logic w_sftq;
  logic w_done;
  logic w_last;

  assign w_last = (r_count == CW'(1));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_qm1   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= w_count_nxt;
      r_qm1   <= w_qm1_nxt;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_count_nxt = r_count;
    w_qm1_nxt   = r_qm1;
    w_ldm       = 1'b0;
    w_ldq       = 1'b0;
    w_clra      = 1'b0;
    w_lda       = 1'b0;
    w_addsub    = 1'b0;
    w_sfta      = 1'b0;
    w_sftq      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_ldm       = 1'b1;
        w_ldq       = 1'b1;
        w_clra      = 1'b1;
        w_qm1_nxt   = 1'b0;
        w_count_nxt = CW'(WIDTH);
        w_next      = S_CHECK;
      end
      S_CHECK: begin
        // Add/sub gets its own cycle so the adder settles before the shift.
        case ({bus.q0, r_qm1})
          2'b10: begin
            w_lda    = 1'b1;
            w_addsub = 1'b1;
            w_next   = S_SHIFT;
          end
          2'b01: begin
            w_lda  = 1'b1;
            w_next = S_SHIFT;
          end
          default: begin
`ifdef BOOTH_SKIP_EN
            w_sfta      = 1'b1;
            w_sftq      = 1'b1;
            w_qm1_nxt   = bus.q0;
            w_count_nxt = r_count - CW'(1);
            w_next      = w_last ? S_DONE : S_CHECK;
`else
            w_next = S_SHIFT;
`endif
          end
        endcase
      end
      S_SHIFT: begin
        w_sfta      = 1'b1;
        w_sftq      = 1'b1;
        w_qm1_nxt   = bus.q0;
        w_count_nxt = r_count - CW'(1);
        w_next      = w_last ? S_DONE : S_CHECK;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = w_done;
  assign bus.ldm    = w_ldm;
  assign bus.ldq    = w_ldq;
  assign bus.clra   = w_clra;
  assign bus.lda    = w_lda;
  assign bus.addsub = w_addsub;
  assign bus.sfta   = w_sfta;
  assign bus.sftq   = w_sftq;
  assign bus.qm1    = r_qm1;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: the controller drives a small A/Q/M/adder datapath and
// products, latency and strobe patterns are compared with hand-computed vectors.
module tb_booth_ctrl;
  localparam int WIDTH = 16;

  logic        clk = 1'b0;
  logic        clr;
  logic [2:0]  dbg_state;
  logic [15:0] m_in;
  logic [15:0] q_in;
  logic [15:0] a_reg;
  logic [15:0] q_reg;
  logic [15:0] m_reg;
  logic [15:0] sum;
  logic [6:0]  strobes;

  int n_checks = 0;
  int n_errors = 0;

  booth_ctrl_if bus ();

  booth_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // datapath: A arithmetic shift, Q shift-in from A[0], M register, A+/-M adder
  assign sum    = bus.addsub ? (a_reg - m_reg) : (a_reg + m_reg);
  assign bus.q0 = q_reg[0];
  assign strobes = {bus.ldm, bus.ldq, bus.clra, bus.lda, bus.addsub, bus.sfta, bus.sftq};

  always @(posedge clk) begin
    if (bus.ldm) m_reg <= m_in;
    if (bus.ldq)       q_reg <= q_in;
    else if (bus.sftq) q_reg <= {a_reg[0], q_reg[15:1]};
    if (bus.clra)      a_reg <= '0;
    else if (bus.lda)  a_reg <= sum;
    else if (bus.sfta) a_reg <= {a_reg[15], a_reg[15:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One multiply. ops = add/sub count, exp_seq = addsub values in lda order.
  task automatic run_mul(input string name, input logic [15:0] m, input logic [15:0] q,
                         input logic [31:0] exp_prod, input int ops, input logic [15:0] exp_seq,
                         input bit restart, input int clr_at);
    int          exp_done;
    int          done_cyc;
    int          n_done;
    int          n_lda;
    int          overlap;
    int          busy_gap;
    logic        after_busy;
    logic [15:0] seq;
    logic [31:0] prod_at_done;
`ifdef BOOTH_SKIP_EN
    exp_done = WIDTH + ops + 2;
`else
    exp_done = 2 * WIDTH + 2;
`endif
    done_cyc = 0; n_done = 0; n_lda = 0; overlap = 0; busy_gap = 0;
    after_busy = 1'b1; seq = '0; prod_at_done = '0;

    @(negedge clk);
    m_in = m;
    q_in = q;
    bus.start = 1'b1;
    @(posedge clk); #1;   // edge 0; now in cycle 1
    bus.start = 1'b0;

    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == 1) check({name, "_load_strobes"}, 32'(strobes), 32'h70);
      if (clr_at != 0 && cyc == clr_at + 1) begin
        clr = 1'b0;
        check({name, "_clr_state"},   32'(dbg_state), 32'd0);
        check({name, "_clr_busy"},    32'(bus.busy),  32'd0);
        check({name, "_clr_qm1"},     32'(bus.qm1),   32'd0);
        check({name, "_clr_strobes"}, 32'({strobes, bus.done}), 32'd0);
        return;
      end
      if (done_cyc == 0 && !bus.busy) busy_gap++;
      if (done_cyc != 0 && cyc == done_cyc + 1) after_busy = bus.busy;
      if (bus.lda) begin
        n_lda++;
        seq = {seq[14:0], bus.addsub};
      end
      if (bus.lda && (bus.sfta || bus.sftq)) overlap++;
      if (bus.done) begin
        n_done++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          prod_at_done = {a_reg, q_reg};
        end
      end
      if (done_cyc != 0 && cyc == done_cyc + 2) break;
      bus.start = restart && (cyc == 5 || cyc == 20);
      clr = (clr_at != 0 && cyc == clr_at);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;

    check({name, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    check({name, "_done_pulses"}, 32'(n_done), 32'd1);
    check({name, "_product"}, prod_at_done, exp_prod);
    check({name, "_product_hold"}, {a_reg, q_reg}, exp_prod);
    check({name, "_lda_count"}, 32'(n_lda), 32'(ops));
    check({name, "_addsub_seq"}, 32'(seq), 32'(exp_seq));
    check({name, "_lda_sft_overlap"}, 32'(overlap), 32'd0);
    check({name, "_busy_gap"}, 32'(busy_gap), 32'd0);
    check({name, "_busy_after_done"}, 32'(after_busy), 32'd0);
  endtask

  initial begin
    clr = 1'b1;
    bus.start = 1'b0;
    m_in = '0;
    q_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state",   32'(dbg_state), 32'd0);
    check("rst_busy",    32'(bus.busy),  32'd0);
    check("rst_done",    32'(bus.done),  32'd0);
    check("rst_qm1",     32'(bus.qm1),   32'd0);
    check("rst_strobes", 32'(strobes),   32'd0);
    clr = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 32'(bus.busy), 32'd0);

    run_mul("m5_q3",     16'd5,     16'd3,     32'h0000000F, 2,  16'h0002, 1'b0, 0);
    run_mul("mneg7_q6",  16'hFFF9,  16'd6,     32'hFFFFFFD6, 2,  16'h0002, 1'b0, 0);
    run_mul("m1_q5555",  16'd1,     16'h5555,  32'h00005555, 16, 16'hAAAA, 1'b0, 0);
    run_mul("q_zero",    16'h1234,  16'h0000,  32'h00000000, 0,  16'h0000, 1'b0, 0);
    run_mul("max_pos",   16'h7FFF,  16'h7FFF,  32'h3FFF0001, 2,  16'h0002, 1'b0, 0);
    run_mul("neg1_neg1", 16'hFFFF,  16'hFFFF,  32'h00000001, 1,  16'h0001, 1'b0, 0);
    run_mul("restart",   16'd5,     16'd3,     32'h0000000F, 2,  16'h0002, 1'b1, 0);
    run_mul("clr_mid",   16'd1,     16'h5555,  32'h00005555, 16, 16'hAAAA, 1'b0, 10);
    run_mul("after_clr", 16'hFFF9,  16'd6,     32'hFFFFFFD6, 2,  16'h0002, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/booth_ctrl.md
# booth_ctrl

Sequencing controller for the radix-2 Booth multiplier. It drives the load, clear and shift strobes of the A (accumulator) and Q (multiplier) 16-bit shift registers and the M (multiplicand) register. It owns the Q₋₁ bit, the iteration counter and the add/subtract decision, and signals completion with a start/busy/done handshake. It sits directly upstream of the shift registers and the A±M adder, which it controls.

## Interface
- WIDTH, 16, operand width; iteration count equals WIDTH; must match the shift register width
- clk  in  1  clock, all state updates on rising edge
- clr  in  1  synchronous, active-high reset
- start  in  1  request a multiply; sampled only in IDLE
- q0  in  1  Q register bit 0 (current multiplier LSB)
- busy  out  1  high from the cycle after start is accepted until DONE inclusive
- done  out  1  one-cycle pulse; product valid on {A,Q}
- ldm  out  1  load M register from operand bus
- ldq  out  1  load Q register from operand bus
- clra  out  1  clear A register
- lda  out  1  load A register with adder result
- addsub  out  1  adder mode: 1 = A−M, 0 = A+M; meaningful only while lda=1
- sfta  out  1  arithmetic right shift of A (external wiring: s_in = A[WIDTH-1])
- sftq  out  1  right shift of Q (external wiring: s_in = A[0])
- qm1  out  1  Q₋₁ bit

## Operation
- States: IDLE, LOAD, CHECK, SHIFT, DONE.
- Count register is $clog2(WIDTH)+1 bits wide.
- IDLE: all strobes 0. If start=1, go to LOAD. Otherwise stay in IDLE.
- LOAD:
  - Assert ldm, ldq and clra.
  - Set qm1←0 and count←WIDTH.
  - Go to CHECK.
- CHECK: decode {q0,qm1}.
  - 10: lda=1, addsub=1.
  - 01: lda=1, addsub=0.
  - 00 or 11: no strobe.
  - Go to SHIFT in all cases.
- SHIFT:
  - Assert sfta and sftq.
  - Set qm1←q0 (the pre-shift value) and count←count−1.
  - If count==1, go to DONE. Otherwise go to CHECK.
- DONE: done=1. Go to IDLE.
- Strobes are decoded combinationally from the state and q0. Only one of ld*/clr*/sft* is active per register per cycle.
- start while busy is ignored; no queuing.
- clr (any state) takes priority over all other behaviour. It forces IDLE, qm1=0 and count=0, and all outputs go to 0 on the next edge. The external registers are not cleared by this block.

## Timing
- Reset values: busy=0, done=0, qm1=0, and every strobe 0.
- start sampled high at edge 0 → LOAD during cycle 1.
- CHECK/SHIFT pairs occupy cycles 2 to 2·WIDTH+1.
- DONE during cycle 2·WIDTH+2. For WIDTH=16, done is high 34 cycles after the start edge.
- The product {A,Q} is stable from the DONE cycle until the next LOAD.
- A new start can be accepted in the first IDLE cycle after DONE. The minimum repeat interval is 2·WIDTH+3 cycles.
- lda and sft* are never asserted in the same cycle, so the adder has one full cycle before each shift.

## Configuration
- BOOTH_SKIP_EN, defined: in CHECK with {q0,qm1} = 00 or 11, the block performs the shift in the CHECK cycle itself.
  - Asserts sfta and sftq.
  - Updates qm1 and count.
  - Stays in CHECK, or goes to DONE if count==1.
  - Latency becomes WIDTH + (number of add/sub operations) + 2 cycles after the start edge.
- BOOTH_SKIP_EN undefined: fixed-latency behaviour as above.

## Test plan
Bench wires booth_ctrl to two shiftreg instances (A, Q), an M register and an A±M adder.
- M=5, Q=3, start pulse → done at cycle 34; {A,Q}=32'h0000000F; exactly one done pulse.
- M=−7 (16'hFFF9), Q=6 → {A,Q}=32'hFFFFFFD6 (−42).
- Q=16'h5555, M=1 → lda asserted 16 times with addsub alternating 1,0,1,0…; Q=0 → lda never asserted. With BOOTH_SKIP_EN, Q=0 → done at cycle 18.
- start re-asserted at cycles 5 and 20 of an operation → ignored; busy stays high; done still at cycle 34; result unchanged.
- clr asserted at cycle 10 → next cycle: state IDLE, busy=0, qm1=0, all strobes 0. A following start runs a full, correct 34-cycle multiply.
